// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencer with data-memory watchdog
// Optional performance counters: HAZARD_PERF_CNT_EN
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_use_stall_ai,
    input  logic             branch_taken_i,
    input  logic             imem_ready_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    input  logic             mdu_start_i,
    input  logic             mdu_done_i,
    output logic             if_stall_o,
    output logic             id_stall_o,
    output logic             ex_stall_o,
    output logic             mem_stall_o,
    output logic             id_flush_o,
    output logic             ex_flush_o,
    output logic             mem_flush_o,
    output logic             wb_flush_o,
    output logic [1:0]       state_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] redir_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MULTI    = 2'd2,
        ST_REDIR    = 2'd3
    } state_e;

    localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic        p1_wait, p2_mdu, redir_taken;
    // stall bits: {mem, ex, id, if}; flush bits: {wb, mem, ex, id}
    logic [3:0]  stall, flush_raw;

    always_comb begin
        p1_wait     = dmem_req_i && !dmem_ready_i;
        p2_mdu      = (mdu_start_i || state_q == ST_MULTI) && !mdu_done_i;
        redir_taken = 1'b0;
        stall       = 4'b0000;
        flush_raw   = 4'b0000;
        state_d     = ST_RUN;

        if (p1_wait) begin
            stall     = 4'b1111;
            flush_raw = 4'b1000;
            state_d   = (state_q == ST_REDIR) ? ST_REDIR : ST_MEM_WAIT;
        end else if (p2_mdu) begin
            stall     = 4'b0111;
            flush_raw = 4'b0100;
            state_d   = ST_MULTI;
        end else if (branch_taken_i) begin
            flush_raw   = 4'b0011;
            redir_taken = 1'b1;
            state_d     = imem_ready_i ? ST_RUN : ST_REDIR;
        end else if (load_use_stall_ai) begin
            stall     = 4'b0011;
            flush_raw = 4'b0010;
        end else if (!imem_ready_i) begin
            stall     = 4'b0001;
            flush_raw = 4'b0001;
        end

        // A stale fetch is outstanding: whatever arrives in IF-ID must be dropped.
        if (state_q == ST_REDIR && !p1_wait) begin
            flush_raw[0] = 1'b1;
            if (!p2_mdu && !branch_taken_i) begin
                stall[0] = stall[0] | !imem_ready_i;
                state_d  = imem_ready_i ? ST_RUN : ST_REDIR;
            end
        end

        if (!rst_ni) begin
            stall       = 4'b0000;
            flush_raw   = 4'b1111;
            redir_taken = 1'b0;
        end

        wait_cnt_d    = p1_wait ? ((wait_cnt_q == TMO) ? wait_cnt_q : wait_cnt_q + 16'd1) : 16'd0;
        mem_timeout_d = mem_timeout_q | (wait_cnt_d == TMO);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 16'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign {mem_stall_o, ex_stall_o, id_stall_o, if_stall_o} = stall;
    // A stalled register keeps its contents even if a bubble was also requested.
    assign id_flush_o    = flush_raw[0] && !stall[1];
    assign ex_flush_o    = flush_raw[1] && !stall[2];
    assign mem_flush_o   = flush_raw[2] && !stall[3];
    assign wb_flush_o    = flush_raw[3];
    assign state_o       = 2'(state_q);
    assign mem_timeout_o = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(stall[0]);
        redir_cnt_d = redir_cnt_q + CNT_W'(redir_taken);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign redir_cnt_o = redir_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = redir_taken;
    assign stall_cnt_o = '0;
    assign redir_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl (MEM_TIMEOUT=4)
module tb_hazard_ctrl;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst_n, lu, br, imr, dreq, drdy, ms, md;
    logic if_s, id_s, ex_s, mem_s, id_f, ex_f, mem_f, wb_f, tmo;
    logic [1:0]  st;
    logic [31:0] scnt, rcnt;
    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_state = 0;
    int          m_wait  = 0;
    bit          m_tmo   = 0;
    logic [31:0] m_scnt  = 0;
    logic [31:0] m_rcnt  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .load_use_stall_ai(lu), .branch_taken_i(br),
        .imem_ready_i(imr), .dmem_req_i(dreq), .dmem_ready_i(drdy),
        .mdu_start_i(ms), .mdu_done_i(md),
        .if_stall_o(if_s), .id_stall_o(id_s), .ex_stall_o(ex_s), .mem_stall_o(mem_s),
        .id_flush_o(id_f), .ex_flush_o(ex_f), .mem_flush_o(mem_f), .wb_flush_o(wb_f),
        .state_o(st), .mem_timeout_o(tmo), .stall_cnt_o(scnt), .redir_cnt_o(rcnt)
    );

    wire [3:0] stall_v = {mem_s, ex_s, id_s, if_s};
    wire [3:0] flush_v = {wb_f, mem_f, ex_f, id_f};

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    task automatic cyc(input bit r, dq, dr, s, d, b, im, l);
        @(posedge clk);
        #1;
        rst_n = r; dreq = dq; drdy = dr; ms = s; md = d; br = b; imr = im; lu = l;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1, 0, 1, 0, 0, 0, 1, 0);
    endtask

    // Model: a hazard freezes the first `depth` pipe registers (PC, IF-ID, ID-EX, EX-MEM)
    // and injects a bubble into the register right after the frozen section.
    task automatic model_eval(output logic [3:0] es, output logic [3:0] ef,
                              output int nstate, output bit taken, output bit dwait);
        int depth = 0;
        bit bub[1:4] = '{0, 0, 0, 0};
        bit mdu;
        taken  = 0;
        nstate = 0;
        dwait  = dreq && !drdy;
        mdu    = (ms || m_state == 2) && !md;
        if (!rst_n) begin
            es = 4'b0000; ef = 4'b1111; dwait = 0;
            return;
        end
        if (dwait) begin
            depth = 4; nstate = (m_state == 3) ? 3 : 1;
        end else if (mdu) begin
            depth = 3; nstate = 2;
        end else if (br) begin
            bub[1] = 1; bub[2] = 1; taken = 1; nstate = imr ? 0 : 3;
        end else if (lu) begin
            depth = 2;
        end else if (!imr) begin
            depth = 1;
        end
        if (m_state == 3 && !dwait) begin
            bub[1] = 1;
            if (!mdu && !br) begin
                if (!imr && depth < 1) depth = 1;
                nstate = imr ? 0 : 3;
            end
        end
        if (depth > 0) bub[depth] = 1;
        for (int i = 0; i < 4; i++) es[i] = (i < depth);
        for (int j = 0; j < 4; j++) ef[j] = bub[j+1] && !(j < 3 && es[j+1]);
    endtask

    task automatic test_reset();
        cyc(0, 0, 1, 0, 0, 0, 1, 0);
        checks++;
        if (stall_v !== 4'b0000 || flush_v !== 4'b1111) begin
            errors++; $display("FAIL reset_out got stall=%b flush=%b exp stall=0000 flush=1111", stall_v, flush_v);
        end
        cyc(0, 0, 1, 0, 0, 0, 1, 0);
        checks++;
        if (st !== 2'd0 || tmo !== 1'b0 || scnt !== 32'd0 || rcnt !== 32'd0) begin
            errors++; $display("FAIL reset_state got st=%0d tmo=%b scnt=%0d rcnt=%0d exp 0", st, tmo, scnt, rcnt);
        end
        idle();
        checks++;
        if (stall_v !== 4'b0000 || flush_v !== 4'b0000 || st !== 2'd0) begin
            errors++; $display("FAIL reset_release got stall=%b flush=%b st=%0d exp 0", stall_v, flush_v, st);
        end
    endtask

    task automatic test_load_use();
        cyc(1, 0, 1, 0, 0, 0, 1, 1);
        checks++;
        if (stall_v !== 4'b0011 || flush_v !== 4'b0010 || st !== 2'd0) begin
            errors++; $display("FAIL load_use got stall=%b flush=%b st=%0d exp 0011 0010 0", stall_v, flush_v, st);
        end
        idle();
        checks++;
        if (stall_v !== 4'b0000 || flush_v !== 4'b0000 || st !== 2'd0) begin
            errors++; $display("FAIL load_use_next got stall=%b flush=%b st=%0d exp 0", stall_v, flush_v, st);
        end
    endtask

    task automatic test_mdu();
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 1, k == 0, 0, k >= 2, 1, 0);
            checks++;
            if (stall_v !== 4'b0111 || flush_v !== 4'b0100 || st !== ((k == 0) ? 2'd0 : 2'd2)) begin
                errors++; $display("FAIL mdu_c%0d got stall=%b flush=%b st=%0d exp 0111 0100", k, stall_v, flush_v, st);
            end
        end
        cyc(1, 0, 1, 0, 1, 1, 1, 0);
        checks++;
        if (stall_v !== 4'b0000 || flush_v !== 4'b0011 || st !== 2'd2) begin
            errors++; $display("FAIL mdu_done got stall=%b flush=%b st=%0d exp 0000 0011 2", stall_v, flush_v, st);
        end
        idle();
        checks++;
        if (st !== 2'd0 || stall_v !== 4'b0000) begin
            errors++; $display("FAIL mdu_after got st=%0d stall=%b exp 0 0000", st, stall_v);
        end
    endtask

    task automatic test_redirect();
        cyc(0, 0, 1, 0, 0, 0, 1, 0);
        cyc(1, 0, 1, 0, 0, 1, 0, 0);
        checks++;
        if (stall_v !== 4'b0000 || flush_v !== 4'b0011 || st !== 2'd0) begin
            errors++; $display("FAIL redir_branch got stall=%b flush=%b st=%0d exp 0000 0011 0", stall_v, flush_v, st);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 1, 0, 0, 0, k == 2, 0);
            checks++;
            if (st !== 2'd3 || flush_v !== 4'b0001 || if_s !== (k != 2)) begin
                errors++; $display("FAIL redir_c%0d got st=%0d flush=%b if_stall=%b exp 3 0001 %b", k, st, flush_v, if_s, k != 2);
            end
        end
        idle();
        checks++;
        if (st !== 2'd0 || flush_v !== 4'b0000 || rcnt !== (PERF ? 32'd1 : 32'd0) || scnt !== (PERF ? 32'd2 : 32'd0)) begin
            errors++; $display("FAIL redir_end got st=%0d flush=%b rcnt=%0d scnt=%0d", st, flush_v, rcnt, scnt);
        end
    endtask

    task automatic test_dmem_wait();
        cyc(0, 0, 1, 0, 0, 0, 1, 0);
        for (int k = 0; k < 6; k++) begin
            cyc(1, 1, 0, 0, 0, 0, 1, 0);
            checks++;
            if (stall_v !== 4'b1111 || flush_v !== 4'b1000 || tmo !== (k >= TMO) || st !== ((k == 0) ? 2'd0 : 2'd1)) begin
                errors++; $display("FAIL dwait_c%0d got stall=%b flush=%b tmo=%b st=%0d", k, stall_v, flush_v, tmo, st);
            end
        end
        cyc(1, 1, 1, 0, 0, 0, 1, 0);
        checks++;
        if (stall_v !== 4'b0000 || st !== 2'd1 || tmo !== 1'b1) begin
            errors++; $display("FAIL dwait_ready got stall=%b st=%0d tmo=%b exp 0000 1 1", stall_v, st, tmo);
        end
        idle();
        checks++;
        if (st !== 2'd0 || tmo !== 1'b1) begin
            errors++; $display("FAIL dwait_sticky got st=%0d tmo=%b exp 0 1", st, tmo);
        end
    endtask

    task automatic test_reset_multi();
        cyc(1, 0, 1, 1, 0, 0, 1, 0);
        idle();
        cyc(0, 0, 1, 0, 0, 0, 1, 0);
        checks++;
        if (stall_v !== 4'b0000 || flush_v !== 4'b1111 || st !== 2'd2) begin
            errors++; $display("FAIL rst_multi got stall=%b flush=%b st=%0d exp 0000 1111 2", stall_v, flush_v, st);
        end
        idle();
        checks++;
        if (st !== 2'd0 || tmo !== 1'b0 || scnt !== 32'd0 || rcnt !== 32'd0 || stall_v !== 4'b0000) begin
            errors++; $display("FAIL rst_multi_after got st=%0d tmo=%b scnt=%0d rcnt=%0d", st, tmo, scnt, rcnt);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] es [0:4] = '{4'b1111, 4'b0111, 4'b0111, 4'b0011, 4'b0000};
        logic [3:0] ef [0:4] = '{4'b1000, 4'b0100, 4'b0100, 4'b0010, 4'b0000};
        logic [1:0] xs [0:4] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0};
        cyc(0, 0, 1, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 1, 0, 0, 1, 1);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) cyc(1, 1, 1, 1, 0, 0, 1, 1);
            if (k == 2) cyc(1, 0, 1, 0, 0, 0, 1, 1);
            if (k == 3) cyc(1, 0, 1, 0, 1, 0, 1, 1);
            if (k == 4) idle();
            checks++;
            if (stall_v !== es[k] || flush_v !== ef[k] || st !== xs[k]) begin
                errors++; $display("FAIL simul_c%0d got stall=%b flush=%b st=%0d exp %b %b %0d", k, stall_v, flush_v, st, es[k], ef[k], xs[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] es, ef;
        int nstate;
        bit taken, dwait;
        cyc(0, 0, 1, 0, 0, 0, 1, 0);
        m_state = 0; m_wait = 0; m_tmo = 0; m_scnt = 0; m_rcnt = 0;
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom % 64) != 0, ($urandom % 3) == 0, ($urandom % 4) != 0, ($urandom % 8) == 0,
                ($urandom % 3) == 0, ($urandom % 6) == 0, ($urandom % 4) != 0, ($urandom % 6) == 0);
            model_eval(es, ef, nstate, taken, dwait);
            checks++;
            if (stall_v !== es || flush_v !== ef) begin
                errors++; $display("FAIL rand_out n=%0d got stall=%b flush=%b exp %b %b", n, stall_v, flush_v, es, ef);
            end
            checks++;
            if (st !== 2'(m_state) || tmo !== m_tmo || scnt !== m_scnt || rcnt !== m_rcnt) begin
                errors++; $display("FAIL rand_status n=%0d got st=%0d tmo=%b scnt=%0d rcnt=%0d exp %0d %b %0d %0d",
                                   n, st, tmo, scnt, rcnt, m_state, m_tmo, m_scnt, m_rcnt);
            end
            if (!rst_n) begin
                m_state = 0; m_wait = 0; m_tmo = 0; m_scnt = 0; m_rcnt = 0;
            end else begin
                m_state = nstate;
                m_wait  = dwait ? ((m_wait < TMO) ? m_wait + 1 : m_wait) : 0;
                if (m_wait == TMO) m_tmo = 1;
                if (PERF) begin
                    m_scnt = m_scnt + 32'(es[0]);
                    m_rcnt = m_rcnt + 32'(taken);
                end
            end
        end
    endtask

    initial begin
        rst_n = 0; lu = 0; br = 0; imr = 1; dreq = 0; drdy = 1; ms = 0; md = 0;
        test_reset();
        test_load_use();
        test_mdu();
        test_redirect();
        test_dmem_wait();
        test_reset_multi();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage core (IF, ID, EX, MEM, WB). It gathers the forwarding unit's load-use request, EX branch redirects, instruction/data memory readiness and multi-cycle EX (MDU) status. From these it drives per-stage pipe-register stall and flush controls. A small FSM tracks multi-cycle conditions (MDU busy, data-memory wait, redirect with a fetch in flight) and a watchdog flags a hung data-memory access.

Parameters:
MEM_TIMEOUT, 255, cycles in a data-memory wait before mem_timeout_o sets (1..2^16-1)
CNT_W, 32, width of performance counters

Ports:
clk_i  in  1  core clock
rst_ni  in  1  reset, synchronous, active-low
load_use_stall_ai  in  1  load-use hazard from forwarding unit (combinational, same cycle)
branch_taken_i  in  1  EX resolved taken branch/jump; PC redirect this cycle
imem_ready_i  in  1  instruction fetch returns valid this cycle
dmem_req_i  in  1  MEM stage holds a load/store
dmem_ready_i  in  1  data memory completes the access this cycle
mdu_start_i  in  1  first cycle of a multi-cycle op in EX
mdu_done_i  in  1  MDU result valid this cycle
if_stall_o, id_stall_o, ex_stall_o, mem_stall_o  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM registers
id_flush_o, ex_flush_o, mem_flush_o, wb_flush_o  out  1 each  load bubble into IF-ID / ID-EX / EX-MEM / MEM-WB
state_o  out  2  FSM state for debug: 0 RUN, 1 MEM_WAIT, 2 MULTI, 3 REDIR
mem_timeout_o  out  1  sticky watchdog flag
stall_cnt_o  out  CNT_W  perf counter (see Optional Feature)
redir_cnt_o  out  CNT_W  perf counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_ni.
- While rst_ni=0, after the edge: state=RUN, wait_cnt=0, mem_timeout_o=0, counters=0. Outputs are combinational: all stalls=0, all flushes=1, so the pipe clears.
- Outputs are combinational from state and inputs; there is zero-cycle latency from any input to the stall/flush outputs. State, wait_cnt and counters are registered.
- Conflict rule: if a stage's stall and flush would both assert, the stall wins and the flush is deasserted.
- Priority, evaluated every cycle:
  - P1 data wait: dmem_req_i && !dmem_ready_i. Stall IF/ID/EX/MEM, assert wb_flush. Next state MEM_WAIT. If the current state is REDIR, stay in REDIR.
  - P2 MDU: (mdu_start_i or state=MULTI) && !mdu_done_i. Stall IF/ID/EX, assert mem_flush. Next state MULTI.
  - P3 redirect: branch_taken_i. Assert id_flush and ex_flush; IF is not stalled (it takes the new PC). If !imem_ready_i, next state REDIR.
  - P4 load-use: load_use_stall_ai. Stall IF/ID, assert ex_flush. Exactly one bubble; the held instruction re-evaluates next cycle.
  - P5 fetch miss: !imem_ready_i. Stall IF, assert id_flush.
- Lower-priority events are never lost. EX/ID are frozen under P1/P2, so branch_taken_i and load_use_stall_ai re-present once released.
- MEM_WAIT: applies P1 while waiting. On dmem_ready_i=1, P2–P5 evaluate normally that cycle and the next state follows those rules (RUN by default).
- MULTI: mdu_start_i and mdu_done_i in the same cycle means no stall and no state change. In MULTI, mdu_done_i=1 releases the stalls that cycle; next state RUN.
- REDIR: a stale fetch is in flight. id_flush=1 every cycle. if_stall = !imem_ready_i. On imem_ready_i=1 the returned instruction is discarded (id_flush=1) and the next state is RUN. P1 overrides the outputs but does not leave REDIR.
- Watchdog: wait_cnt increments each cycle P1 holds and clears when P1 is false. When wait_cnt==MEM_TIMEOUT, mem_timeout_o sets and stays set until reset; wait_cnt saturates.
- Reset mid-operation: any state returns to RUN on the next edge. No pending condition is retained.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: stall_cnt_o increments each cycle if_stall_o=1. redir_cnt_o increments each cycle P3 is taken. Both wrap modulo 2^CNT_W and clear on reset.
- Undefined: both ports are still present, tied to 0, with no counter flops.

Test Plan:
1. Load-use: load_use_stall_ai=1 for 1 cycle, all ready → that cycle if/id_stall=1 and ex_flush=1; next cycle all 0; state stays 0.
2. MDU: mdu_start_i=1, mdu_done_i at cycle +4 → if/id/ex_stall=1 and mem_flush=1 for cycles 0–3; state_o=2 for 1–4; released at cycle 4; branch_taken_i held during the stall is honoured at cycle 4 (id_flush=ex_flush=1).
3. Redirect with fetch in flight: branch_taken_i=1, imem_ready_i=0 for 3 cycles → state_o=3, id_flush=1 through the ready cycle, then state 0; redir_cnt_o=1 with the macro, 0 without.
4. Data wait plus watchdog (MEM_TIMEOUT=4): dmem_req_i=1, dmem_ready_i=0 for 6 cycles → IF–MEM stalled, wb_flush=1; mem_timeout_o rises after the 4th wait cycle and stays 1 after ready.
5. Simultaneous P1+P2+P4 → only the P1 outputs assert; after dmem_ready_i the MDU stall begins.
6. rst_ni=0 for 1 cycle while in MULTI → state_o=0, all flushes=1 during reset, counters=0, mem_timeout_o=0.
